// File: rtl/iomem_dbg_pkg.sv
// Shared constants and types for the byte-stream iomem debug bridge.
package iomem_dbg_pkg;

   // Command bytes accepted on the receive stream
   localparam logic [7:0] CMD_WR  = 8'h57;   // 'W'
   localparam logic [7:0] CMD_RD  = 8'h52;   // 'R'

   // Single-byte responses returned on the transmit stream
   localparam logic [7:0] RSP_OK  = 8'h4B;   // 'K'
   localparam logic [7:0] RSP_ERR = 8'h45;   // 'E'
   localparam logic [7:0] RSP_TMO = 8'h54;   // 'T'

   // Byte counter covers the four bytes of an address or data field
   localparam int CNT_W = 2;
   localparam logic [CNT_W-1:0] CNT_ZERO = 2'd0;
   localparam logic [CNT_W-1:0] CNT_ONE  = 2'd1;
   localparam logic [CNT_W-1:0] CNT_LAST = 2'd3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      DATA = 3'd2,
      BUS  = 3'd3,
      RESP = 3'd4
   } state_t;

endpackage

// File: rtl/iomem_dbg_txser.sv
// Response serialiser: loads a one- or four-byte response and sends it MSB
// first on a registered valid/ready byte stream.
module iomem_dbg_txser
   import iomem_dbg_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic        four,
   input  logic [31:0] word,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        done
);

   logic [23:0]      rest_r;
   logic [CNT_W-1:0] left_r;

   // Final byte is being accepted this cycle
   assign done = tx_valid && tx_ready && (left_r == CNT_ZERO);

   // Load a response, then advance one byte per accepted transfer
   always_ff @(posedge clk) begin
      if (!resetn) begin
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
         rest_r   <= 24'h000000;
         left_r   <= CNT_ZERO;
      end else if (load) begin
         tx_valid <= 1'b1;
         if (four) begin
            tx_data <= word[31:24];
            rest_r  <= word[23:0];
            left_r  <= CNT_LAST;
         end else begin
            tx_data <= word[7:0];
            rest_r  <= 24'h000000;
            left_r  <= CNT_ZERO;
         end
      end else if (tx_valid && tx_ready) begin
         if (left_r == CNT_ZERO) begin
            tx_valid <= 1'b0;
         end else begin
            tx_data <= rest_r[23:16];
            rest_r  <= {rest_r[15:0], 8'h00};
            left_r  <= left_r - CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/iomem_dbg_bridge.sv
// Debug bridge: decodes 'W'/'R' commands from a byte stream, runs one iomem
// transaction per command and returns 'K', read data, 'E' or 'T'.
module iomem_dbg_bridge
   import iomem_dbg_pkg::*;
#(
   parameter int         TIMEOUT = 1024,
   parameter logic [7:0] ADDR_HI = 8'h03
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        iomem_valid,
   input  logic        iomem_ready,
   output logic [3:0]  iomem_wstrb,
   output logic [31:0] iomem_addr,
   output logic [31:0] iomem_wdata,
   input  logic [31:0] iomem_rdata
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT);

   state_t           state_r;
   logic             op_wr_r;
   logic [CNT_W-1:0] byte_cnt_r;
   logic [15:0]      tmo_cnt_r;
   logic             tx_load_r;
   logic             tx_four_r;
   logic [31:0]      tx_word_r;
   logic             tx_done_s;

   // Command decode, bus handshake and response sequencing
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r     <= IDLE;
         op_wr_r     <= 1'b0;
         byte_cnt_r  <= CNT_ZERO;
         tmo_cnt_r   <= 16'h0000;
         tx_load_r   <= 1'b0;
         tx_four_r   <= 1'b0;
         tx_word_r   <= 32'h00000000;
         rx_ready    <= 1'b0;
         iomem_valid <= 1'b0;
         iomem_wstrb <= 4'h0;
         iomem_addr  <= 32'h00000000;
         iomem_wdata <= 32'h00000000;
      end else begin
         tx_load_r <= 1'b0;
         case (state_r)
            IDLE: begin
               rx_ready <= 1'b1;
               if (rx_valid && rx_ready) begin
                  if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
                     op_wr_r    <= (rx_data == CMD_WR);
                     byte_cnt_r <= CNT_ZERO;
                     state_r    <= ADDR;
                  end
               end
            end
            ADDR: begin
               if (rx_valid && rx_ready) begin
                  iomem_addr <= {iomem_addr[23:0], rx_data};
                  byte_cnt_r <= byte_cnt_r + CNT_ONE;
                  if (byte_cnt_r == CNT_LAST) begin
                     // iomem_addr[23:16] becomes the top byte after this shift
                     if (iomem_addr[23:16] != ADDR_HI) begin
                        rx_ready  <= 1'b0;
                        tx_load_r <= 1'b1;
                        tx_four_r <= 1'b0;
                        tx_word_r <= {24'h000000, RSP_ERR};
                        state_r   <= RESP;
                     end else if (op_wr_r) begin
                        state_r <= DATA;
                     end else begin
                        rx_ready    <= 1'b0;
                        iomem_valid <= 1'b1;
                        iomem_wstrb <= 4'h0;
                        tmo_cnt_r   <= 16'h0000;
                        state_r     <= BUS;
                     end
                  end
               end
            end
            DATA: begin
               if (rx_valid && rx_ready) begin
                  iomem_wdata <= {iomem_wdata[23:0], rx_data};
                  byte_cnt_r  <= byte_cnt_r + CNT_ONE;
                  if (byte_cnt_r == CNT_LAST) begin
                     rx_ready    <= 1'b0;
                     iomem_valid <= 1'b1;
                     iomem_wstrb <= 4'hF;
                     tmo_cnt_r   <= 16'h0000;
                     state_r     <= BUS;
                  end
               end
            end
            BUS: begin
               if (iomem_valid) begin
                  // A ready arriving on the timeout cycle still completes
                  if (iomem_ready) begin
                     iomem_valid <= 1'b0;
                     iomem_wstrb <= 4'h0;
                     tx_load_r   <= 1'b1;
                     tx_four_r   <= !op_wr_r;
                     tx_word_r   <= op_wr_r ? {24'h000000, RSP_OK} : iomem_rdata;
                     state_r     <= RESP;
                  end else if ((tmo_cnt_r + 16'd1) == TMO_LAST) begin
                     tmo_cnt_r   <= TMO_LAST;
                     iomem_valid <= 1'b0;
                     iomem_wstrb <= 4'h0;
                     tx_load_r   <= 1'b1;
                     tx_four_r   <= 1'b0;
                     tx_word_r   <= {24'h000000, RSP_TMO};
                     state_r     <= RESP;
                  end else begin
                     tmo_cnt_r <= tmo_cnt_r + 16'd1;
                  end
               end else begin
                  rx_ready <= 1'b1;
                  state_r  <= IDLE;
               end
            end
            RESP: begin
               if (tx_done_s) begin
                  rx_ready <= 1'b1;
                  state_r  <= IDLE;
               end
            end
            default: begin
               rx_ready    <= 1'b0;
               iomem_valid <= 1'b0;
               iomem_wstrb <= 4'h0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   iomem_dbg_txser u_txser (
      .clk      (clk),
      .resetn   (resetn),
      .load     (tx_load_r),
      .four     (tx_four_r),
      .word     (tx_word_r),
      .tx_ready (tx_ready),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .done     (tx_done_s)
   );

endmodule

// File: tb/tb_iomem_dbg_bridge.sv
// Scoreboard bench for iomem_dbg_bridge: a reference model queues expected bus
// transactions and response bytes; negedge monitors pop and compare them.
module tb_iomem_dbg_bridge;

   localparam int TMO = 16;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          cycles;
   } bus_t;

   logic        clk;
   logic        resetn;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   int n_cmp  = 0;
   int n_fail = 0;

   bus_t       exp_bus[$];
   logic [7:0] exp_tx[$];

   // responder configuration and state
   int          lat_cfg   = 1;
   logic [31:0] rd_cfg    = 32'h0;
   bit          use_gpio  = 1'b0;
   logic [31:0] gpio_reg  = 32'h0;
   logic [31:0] model_gpio = 32'h0;
   int          vcyc      = 0;

   // sink state
   int          stall_cnt = 0;
   bit          stall_req = 1'b0;
   bit          pv = 1'b0, pr = 1'b0;
   logic [7:0]  pd = 8'h00;

   iomem_dbg_bridge #(.TIMEOUT(TMO), .ADDR_HI(8'h03)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_ready    (rx_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic flag(input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   // Bus responder and bus-side scoreboard
   always @(negedge clk) begin
      if (!resetn) begin
         vcyc        = 0;
         iomem_ready = 1'b0;
         iomem_rdata = 32'h0;
      end else if (iomem_valid) begin
         if (vcyc == 0 && exp_bus.size() == 0) flag("bus_unexpected");
         vcyc++;
         if (exp_bus.size() > 0) begin
            chk("bus_addr", iomem_addr, exp_bus[0].addr);
            chk("bus_wstrb", {28'h0, iomem_wstrb}, {28'h0, exp_bus[0].wstrb});
            if (exp_bus[0].wstrb == 4'hF) chk("bus_wdata", iomem_wdata, exp_bus[0].wdata);
         end
         iomem_ready = (vcyc == lat_cfg);
         iomem_rdata = use_gpio ? gpio_reg : rd_cfg;
         if (iomem_ready && iomem_wstrb == 4'hF) gpio_reg = iomem_wdata;
      end else begin
         if (vcyc > 0) begin
            if (exp_bus.size() > 0) begin
               chk("bus_cycles", vcyc, exp_bus[0].cycles);
               void'(exp_bus.pop_front());
            end
            vcyc = 0;
         end
         // ready noise outside a transaction must be ignored
         iomem_ready = 1'($urandom_range(0, 1));
         iomem_rdata = $urandom;
      end
   end

   // Response sink and tx-side scoreboard
   always @(negedge clk) begin
      if (!resetn) begin
         tx_ready = 1'b0;
         pv = 1'b0;
         pr = 1'b0;
      end else begin
         if (pv && !pr) begin
            chk("tx_hold_valid", {31'h0, tx_valid}, 32'h1);
            chk("tx_hold_data", {24'h0, tx_data}, {24'h0, pd});
         end
         if (stall_cnt > 0) begin
            tx_ready = 1'b0;
            stall_cnt--;
         end else begin
            tx_ready = ($urandom_range(0, 3) != 0);
         end
         if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
               flag("tx_unexpected");
            end else begin
               chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
               if (stall_req) begin
                  stall_req = 1'b0;
                  stall_cnt = 5;
               end
            end
         end
         pv = tx_valid;
         pr = tx_ready;
         pd = tx_data;
      end
   end

   // Present one byte (called at a negedge) and wait until it is taken
   task automatic send_byte(input logic [7:0] b);
      int n;
      rx_valid = 1'b1;
      rx_data  = b;
      n = 0;
      while (!rx_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) flag("rx_accept_timeout");
      @(negedge clk);
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   // Reference model: expected bus cycle and response bytes of one command
   task automatic issue_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input int lat, input logic [31:0] rd, input bit ug);
      bus_t e;
      logic [31:0] rv;
      bit good;
      lat_cfg  = lat;
      rd_cfg   = rd;
      use_gpio = ug;
      good = (a[31:24] == 8'h03);
      if (!good) begin
         exp_tx.push_back(8'h45);
      end else begin
         e.addr   = a;
         e.wdata  = d;
         e.wstrb  = wr ? 4'hF : 4'h0;
         e.cycles = (lat <= TMO) ? lat : TMO;
         exp_bus.push_back(e);
         if (lat > TMO) begin
            exp_tx.push_back(8'h54);
         end else if (wr) begin
            exp_tx.push_back(8'h4B);
            model_gpio = d;
         end else begin
            rv = ug ? model_gpio : rd;
            for (int i = 3; i >= 0; i--) exp_tx.push_back(rv[8*i +: 8]);
         end
      end
      send_byte(wr ? 8'h57 : 8'h52);
      for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
      if (wr && good) for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (exp_tx.size() != 0 || exp_bus.size() != 0) begin
         flag("response_timeout");
         exp_tx.delete();
         exp_bus.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_iomem_valid"}, {31'h0, iomem_valid}, 32'h0);
      chk({tag, "_iomem_wstrb"}, {28'h0, iomem_wstrb}, 32'h0);
      chk({tag, "_iomem_addr"}, iomem_addr, 32'h0);
      chk({tag, "_iomem_wdata"}, iomem_wdata, 32'h0);
      chk({tag, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
      chk({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
      chk({tag, "_rx_ready"}, {31'h0, rx_ready}, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [7:0]  t;
      bit          wr;
      resetn   = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      resetn = 1'b1;
      @(negedge clk);

      // write then read back through the GPIO register model
      issue_cmd(1'b1, 32'h03000000, 32'h00000005, 1, 32'h0, 1'b0);
      wait_idle();
      chk("gpio_after_write", gpio_reg, 32'h00000005);
      issue_cmd(1'b0, 32'h03000000, 32'h0, 2, 32'h0, 1'b1);
      wait_idle();

      // read with a mid-stream transmit stall
      stall_req = 1'b1;
      issue_cmd(1'b0, 32'h03000000, 32'h0, 3, 32'hDEADBEEF, 1'b0);
      wait_idle();

      // rejected address
      issue_cmd(1'b0, 32'h02000000, 32'h0, 1, 32'h0, 1'b0);
      wait_idle();

      // responder never answers, then a normal command
      issue_cmd(1'b0, 32'h03000010, 32'h0, 1000, 32'h0, 1'b0);
      wait_idle();
      issue_cmd(1'b1, 32'h03000004, 32'h12345678, 2, 32'h0, 1'b0);
      wait_idle();

      // ready on the timeout cycle completes; one cycle later times out
      issue_cmd(1'b0, 32'h03000020, 32'h0, TMO, 32'hCAFEF00D, 1'b0);
      wait_idle();
      issue_cmd(1'b1, 32'h03000024, 32'hA5A5A5A5, TMO + 1, 32'h0, 1'b0);
      wait_idle();

      // garbage in IDLE produces nothing
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h41);
      repeat (20) @(negedge clk);
      chk("garbage_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("garbage_iomem_valid", {31'h0, iomem_valid}, 32'h0);

      // reset part-way through a command, then a full read
      send_byte(8'h57);
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'h00);
      resetn = 1'b0;
      @(negedge clk);
      check_reset_outputs("midreset");
      resetn = 1'b1;
      @(negedge clk);
      issue_cmd(1'b0, 32'h03000008, 32'h0, 4, 32'h0BADC0DE, 1'b0);
      wait_idle();

      // back-to-back commands rely on rx back-pressure
      issue_cmd(1'b0, 32'h0300000C, 32'h0, 3, 32'h11223344, 1'b0);
      issue_cmd(1'b0, 32'h0300000C, 32'h0, 3, 32'h11223344, 1'b0);
      wait_idle();

      // randomized commands
      for (int k = 0; k < 40; k++) begin
         wr = 1'($urandom_range(0, 1));
         a  = {8'h03, 24'($urandom)};
         if ($urandom_range(0, 4) == 0) begin
            t = 8'($urandom_range(0, 255));
            if (t == 8'h03) t = 8'h04;
            a[31:24] = t;
         end
         issue_cmd(wr, a, $urandom, $urandom_range(1, TMO + 4), $urandom,
                   !wr && ($urandom_range(0, 3) == 0));
         wait_idle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
